// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and
// oversampling constants used by both directions on the same tick.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int START_MID  = 7;

  localparam logic [3:0] CYC_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] CYC_MID  = 4'(START_MID);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Ports: i_clk, i_rst (sync, active high), i_d (async in), o_q (synced out).
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, 16x oversampled on i_sample_tick.
// Ports: i_clk, i_rst, i_sample_tick, i_rx, i_rxq_full in;
//        o_data, o_enq_rxq, o_frame_err, o_overrun out.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sample_tick,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_enq_rxq,
  input  logic       i_rxq_full,
  output logic       o_frame_err,
  output logic       o_overrun
);

  logic       w_rx_s;
  state_t     r_state;
  logic [3:0] r_cycle;
  logic [2:0] r_bit;
  logic [7:0] r_sh;
  logic [7:0] r_data;
  logic       r_enq;
  logic       r_ferr;
  logic       r_ovr;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (w_rx_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cycle <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_enq   <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_enq  <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      if (i_sample_tick) begin
        case (r_state)
          IDLE: begin
            if (!w_rx_s) begin
              r_state <= START;
              r_cycle <= '0;
            end
          end
          START: begin
            if (r_cycle == CYC_MID) begin
              // High at mid start bit: a glitch, not a frame.
              if (!w_rx_s) begin
                r_state <= DATA;
                r_cycle <= '0;
                r_bit   <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_cycle <= r_cycle + 4'd1;
            end
          end
          DATA: begin
            if (r_cycle == CYC_LAST) begin
              r_sh    <= {w_rx_s, r_sh[7:1]};
              r_cycle <= '0;
              if (r_bit == BIT_LAST) begin
                r_state <= STOP;
              end else begin
                r_bit <= r_bit + 3'd1;
              end
            end else begin
              r_cycle <= r_cycle + 4'd1;
            end
          end
          STOP: begin
            // Decide at mid stop so the next start edge is not missed.
            if (r_cycle == CYC_LAST) begin
              if (!w_rx_s) begin
                r_ferr  <= 1'b1;
                r_state <= RECOVER;
              end else if (i_rxq_full) begin
                r_ovr   <= 1'b1;
                r_state <= IDLE;
              end else begin
                r_data  <= r_sh;
                r_enq   <= 1'b1;
                r_state <= IDLE;
              end
            end else begin
              r_cycle <= r_cycle + 4'd1;
            end
          end
          RECOVER: begin
            // Wait out a held-low line before hunting for starts.
            if (w_rx_s) begin
              r_state <= IDLE;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_data      = r_data;
  assign o_enq_rxq   = r_enq;
  assign o_frame_err = r_ferr;
  assign o_overrun   = r_ovr;

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frame-level reference model,
// directed scenarios followed by randomized frames.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_sample_tick = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_rxq_full = 1'b0;
  logic [7:0] o_data;
  logic       o_enq_rxq;
  logic       o_frame_err;
  logic       o_overrun;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  localparam int K_ENQ = 0;
  localparam int K_OVR = 1;
  localparam int K_FER = 2;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;
  int         tcnt = 0;

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_sample_tick (i_sample_tick),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_enq_rxq     (o_enq_rxq),
    .i_rxq_full    (i_rxq_full),
    .o_frame_err   (o_frame_err),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks.
  initial begin
    forever begin
      @(negedge clk);
      tcnt++;
      i_sample_tick = (tcnt % 4 == 0);
    end
  end

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic hold_ticks(logic v, int n);
    i_rx = v;
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic push_exp(int kind, logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Reference model: a frame's outcome is fixed by its stop bit and
  // the queue-full flag alone.
  task automatic send_frame(logic [7:0] b, logic stop_v, logic full);
    i_rxq_full = full;
    if (!stop_v) begin
      push_exp(K_FER, last_good);
    end else if (full) begin
      push_exp(K_OVR, last_good);
    end else begin
      push_exp(K_ENQ, b);
      last_good = b;
    end
    hold_ticks(1'b0, 16);
    for (int i = 0; i < 8; i++) hold_ticks(b[i], 16);
    hold_ticks(stop_v, 16);
  endtask

  task automatic reset_check(string tag);
    check({tag, "_data"}, int'(o_data), 0);
    check({tag, "_pulses"},
          int'({o_enq_rxq, o_overrun, o_frame_err}), 0);
  endtask

  // Monitor: each pulse cycle consumes one expected outcome.
  always @(negedge clk) begin
    if (!i_rst && (o_enq_rxq || o_overrun || o_frame_err)) begin
      check("excl",
            $countones({o_enq_rxq, o_overrun, o_frame_err}), 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected: got pulses %b, expected none",
                 {o_enq_rxq, o_overrun, o_frame_err});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("kind",
              o_enq_rxq ? K_ENQ : (o_overrun ? K_OVR : K_FER),
              e.kind);
        check("data", int'(o_data), int'(e.data));
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    reset_check("rst0");
    i_rst = 1'b0;
    hold_ticks(1'b1, 20);

    // Single byte.
    send_frame(8'hA5, 1'b1, 1'b0);
    hold_ticks(1'b1, 8);

    // Back-to-back, one stop bit each.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold_ticks(1'b1, 16);

    // Short low glitch on idle line.
    hold_ticks(1'b0, 4);
    hold_ticks(1'b1, 20);
    send_frame(8'h5A, 1'b1, 1'b0);
    hold_ticks(1'b1, 8);

    // Framing error followed by a break.
    send_frame(8'h81, 1'b0, 1'b0);
    hold_ticks(1'b0, 40);
    hold_ticks(1'b1, 32);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold_ticks(1'b1, 8);

    // Queue full: overrun, data register untouched.
    send_frame(8'h55, 1'b1, 1'b1);
    hold_ticks(1'b1, 8);
    i_rxq_full = 1'b0;
    hold_ticks(1'b1, 8);

    // Reset in the middle of data bit 4 of 0xC3.
    begin
      logic [7:0] b;
      b = 8'hC3;
      hold_ticks(1'b0, 16);
      for (int i = 0; i < 4; i++) hold_ticks(b[i], 16);
      hold_ticks(b[4], 8);
      i_rst = 1'b1;
      @(negedge clk);
      i_rst = 1'b0;
      last_good = 8'h00;
      reset_check("rst_mid");
      hold_ticks(1'b1, 32);
    end
    send_frame(8'hFF, 1'b1, 1'b0);
    hold_ticks(1'b1, 8);

    // Randomized frames.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      int         r;
      b = 8'($urandom);
      r = $urandom_range(0, 9);
      send_frame(b, r != 1, r == 0);
      if (r == 1) begin
        hold_ticks(1'b0, $urandom_range(0, 30));
        hold_ticks(1'b1, $urandom_range(2, 20));
      end else begin
        hold_ticks(1'b1, $urandom_range(0, 20));
      end
    end
    hold_ticks(1'b1, 16);
    i_rxq_full = 1'b0;

    // Bounded drain of the scoreboard.
    begin
      int budget;
      budget = 2000;
      while (exp_q.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      check("drain", exp_q.size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
